// File: rtl/imem_dmem_sequencer_pkg.sv
// Shared types and constants for the instruction/data memory sequencer.
package imem_dmem_sequencer_pkg;

  localparam int ADDR_W      = 11;
  localparam int DATA_W      = 24;
  localparam int INSTR_W     = 28;
  localparam int INSTR_BYTES = 4;

  // Instruction bytes live from this address upward, one byte per word.
  localparam logic [ADDR_W-1:0] IMEM_BASE = 11'd1024;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRD,
    DRD_CAP,
    DWR
  } state_t;

  // Fetch addresses are word-of-bytes aligned: the two low bits are dropped.
  function automatic logic [ADDR_W-1:0] align_fetch(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/imem_dmem_sequencer_arb.sv
// Fetch/data arbiter: data wins unless a fetch has waited DATA_BURST_MAX grants.
module mem_req_arb
  import imem_dmem_sequencer_pkg::*;
#(
  parameter int DATA_BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic grant_if,
  output logic grant_d
);

  localparam int CNT_W = $clog2(DATA_BURST_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             fetch_forced;

  // Priority selection; only meaningful while the sequencer is idle.
  always_comb begin
    fetch_forced = if_req && (starve_cnt == CNT_W'(DATA_BURST_MAX));
    grant_if     = arb_en && if_req && (!d_req || fetch_forced);
    grant_d      = arb_en && d_req && !fetch_forced;
  end

  // Count data grants that overtook a waiting fetch; cleared once it is served or gone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!if_req || grant_if) begin
        starve_cnt <= '0;
      end else if (grant_d) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_dmem_sequencer.sv
// Shares one single-port memory between instruction fetch (4 byte reads
// assembled big-endian into one instruction) and single-word data accesses.
// All outputs, including the memory strobes, are registered.
module imem_dmem_sequencer
  import imem_dmem_sequencer_pkg::*;
#(
  parameter int DATA_BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  input  logic               if_flush,
  output logic               if_gnt,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic               d_gnt,
  output logic               d_valid,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               mem_memread,
  output logic               mem_memwrite,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [DATA_W-1:0]  mem_writedata,
  input  logic [DATA_W-1:0]  mem_memdata
);

  state_t              state, state_nxt;
  logic [2:0]          k_q, k_nxt;
  logic [ADDR_W-1:0]   base_q, base_nxt;
  logic [23:0]         asm_q, asm_nxt;
  logic                grant_if, grant_d;

  logic                if_gnt_nxt, if_valid_nxt, d_gnt_nxt, d_valid_nxt;
  logic                rd_nxt, wr_nxt;
  logic [INSTR_W-1:0]  if_instr_nxt;
  logic [DATA_W-1:0]   d_rdata_nxt, wdata_nxt;
  logic [ADDR_W-1:0]   addr_nxt;

  mem_req_arb #(
    .DATA_BURST_MAX(DATA_BURST_MAX)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .arb_en   (state == IDLE),
    .if_req   (if_req),
    .d_req    (d_req),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  // Next state plus next value of every registered output.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned and infers a latch.
    state_nxt    = state;
    k_nxt        = k_q;
    base_nxt     = base_q;
    asm_nxt      = asm_q;
    if_gnt_nxt   = 1'b0;
    if_valid_nxt = 1'b0;
    if_instr_nxt = if_instr;
    d_gnt_nxt    = 1'b0;
    d_valid_nxt  = 1'b0;
    d_rdata_nxt  = d_rdata;
    rd_nxt       = 1'b0;
    wr_nxt       = 1'b0;
    addr_nxt     = mem_address;
    wdata_nxt    = mem_writedata;

    unique case (state)
      IDLE: begin
        if (grant_if) begin
          state_nxt  = FETCH;
          k_nxt      = 3'd0;
          base_nxt   = align_fetch(if_addr);
          if_gnt_nxt = 1'b1;
          rd_nxt     = 1'b1;
          addr_nxt   = align_fetch(if_addr);
        end else if (grant_d) begin
          d_gnt_nxt = 1'b1;
          addr_nxt  = d_addr;
          if (d_we) begin
            state_nxt = DWR;
            wr_nxt    = 1'b1;
            wdata_nxt = d_wdata;
          end else begin
            state_nxt = DRD;
            rd_nxt    = 1'b1;
          end
        end
      end

      FETCH: begin
        if (if_flush) begin
          state_nxt = IDLE;
        end else if (k_q == 3'(INSTR_BYTES)) begin
          state_nxt    = IDLE;
          if_valid_nxt = 1'b1;
          if_instr_nxt = {asm_q[19:0], mem_memdata[7:0]};
        end else begin
          if (k_q != 3'd0) begin
            asm_nxt = {asm_q[15:0], mem_memdata[7:0]};
          end
          k_nxt = k_q + 3'd1;
          // Set up the next byte read while bytes remain.
          if (k_q < 3'(INSTR_BYTES - 1)) begin
            rd_nxt   = 1'b1;
            addr_nxt = base_q + ADDR_W'(k_q + 3'd1);
          end
        end
      end

      DRD: begin
        state_nxt = DRD_CAP;
      end

      DRD_CAP: begin
        state_nxt   = IDLE;
        d_valid_nxt = 1'b1;
        d_rdata_nxt = mem_memdata;
      end

      DWR: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
      state <= state_nxt;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q           <= '0;
      base_q        <= '0;
      asm_q         <= '0;
      if_gnt        <= 1'b0;
      if_valid      <= 1'b0;
      if_instr      <= '0;
      d_gnt         <= 1'b0;
      d_valid       <= 1'b0;
      d_rdata       <= '0;
      mem_memread   <= 1'b0;
      mem_memwrite  <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      k_q           <= k_nxt;
      base_q        <= base_nxt;
      asm_q         <= asm_nxt;
      if_gnt        <= if_gnt_nxt;
      if_valid      <= if_valid_nxt;
      if_instr      <= if_instr_nxt;
      d_gnt         <= d_gnt_nxt;
      d_valid       <= d_valid_nxt;
      d_rdata       <= d_rdata_nxt;
      mem_memread   <= rd_nxt;
      mem_memwrite  <= wr_nxt;
      mem_address   <= addr_nxt;
      mem_writedata <= wdata_nxt;
    end
  end

endmodule
